// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the requesters, the arbiter and the uart transmit FIFO write port.
// The master side is the producer/uart environment; the slave side is the arbiter.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DBIT  = 8
);
  logic [N_REQ-1:0]      req;
  logic [N_REQ-1:0]      valid;
  logic [N_REQ-1:0]      last;
  logic [N_REQ*DBIT-1:0] data;
  logic [N_REQ-1:0]      ready;
  logic [N_REQ-1:0]      grant;
  logic                  tx_full;
  logic                  wr_uart;
  logic [DBIT-1:0]       w_data;
  logic                  busy;
  logic                  abort_tick;

  modport master (
    output req, valid, last, data, tx_full,
    input  ready, grant, wr_uart, w_data, busy, abort_tick
  );

  modport slave (
    input  req, valid, last, data, tx_full,
    output ready, grant, wr_uart, w_data, busy, abort_tick
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing one uart tx FIFO write port among N_REQ requesters.
// A grant ends on the last accepted byte, on requester withdrawal, or after TIMEOUT idle cycles.
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DBIT    = 8,
  parameter int TIMEOUT = 1024,
  parameter int TW      = 10
) (
  input logic            clk,
  input logic            reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PW:0] NR = (PW+1)'(N_REQ);

  typedef enum logic {IDLE, XFER} state_t;

  state_t           state;
  logic [N_REQ-1:0] grant_q;
  logic [PW-1:0]    rr_ptr;
  logic [TW-1:0]    count;
  logic             abort_q;

  logic [PW-1:0]    g_idx;
  logic             g_valid;
  logic             g_last;
  logic             g_req;
  logic [DBIT-1:0]  g_data;
  logic [PW-1:0]    pick_idx;
  logic             pick_found;
  logic [PW:0]      cand_sum;
  logic             accept;
  logic             expire;

  always_comb begin
    g_idx   = '0;
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_req   = 1'b0;
    g_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        g_idx   = PW'(i);
        g_valid = bus.valid[i];
        g_last  = bus.last[i];
        g_req   = bus.req[i];
        g_data  = bus.data[i*DBIT +: DBIT];
      end
    end
  end

  // Search starts just past the previous owner so every requester gets a turn.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_sum   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand_sum = {1'b0, rr_ptr} + (PW+1)'(k);
      if (cand_sum >= NR) begin
        cand_sum = cand_sum - NR;
      end
      if (!pick_found && bus.req[cand_sum[PW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand_sum[PW-1:0];
      end
    end
  end

  assign accept = (state == XFER) && g_valid && !bus.tx_full;
  assign expire = !accept && !bus.tx_full && (count == TW'(TIMEOUT-1));

  assign bus.ready      = (state == XFER && !bus.tx_full) ? grant_q : '0;
  assign bus.wr_uart    = accept;
  assign bus.w_data     = accept ? g_data : '0;
  assign bus.grant      = grant_q;
  assign bus.busy       = (state == XFER);
  assign bus.abort_tick = abort_q;

  // Release priority: completed packet, then withdrawal, then idle timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      grant_q <= '0;
      rr_ptr  <= PW'(N_REQ-1);
      count   <= '0;
      abort_q <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            state   <= XFER;
            grant_q <= N_REQ'(1) << pick_idx;
            count   <= '0;
          end
        end
        XFER: begin
          if ((accept && g_last) || (!g_req && !accept)) begin
            state   <= IDLE;
            grant_q <= '0;
            rr_ptr  <= g_idx;
            count   <= '0;
          end else if (expire) begin
            state   <= IDLE;
            grant_q <= '0;
            rr_ptr  <= g_idx;
            count   <= '0;
            abort_q <= 1'b1;
          end else if (accept) begin
            count <= '0;
          end else if (!bus.tx_full) begin
            count <= count + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end
endmodule
